// File: rtl/pad_io_ctrl_pkg.sv
// Shared constants for the single-pad controller: register map, attribute
// bit positions, drive-strength encodings and the break-before-make FSM states.
package pad_io_ctrl_pkg;

  localparam logic [1:0] ADDR_OUT  = 2'd0;
  localparam logic [1:0] ADDR_ATTR = 2'd1;
  localparam logic [1:0] ADDR_DBNC = 2'd2;
  localparam logic [1:0] ADDR_IRQ  = 2'd3;

  localparam int ATTR_INV = 0;
  localparam int ATTR_OD  = 1;
  localparam int ATTR_PD  = 2;
  localparam int ATTR_PU  = 3;
  localparam int ATTR_KP  = 4;
  localparam int ATTR_DRV = 5;

  localparam logic STRONG_DRIVE = 1'b0;
  localparam logic WEAK_DRIVE   = 1'b1;

  localparam int IRQ_RISE_EN  = 0;
  localparam int IRQ_FALL_EN  = 1;
  localparam int IRQ_RISE_CLR = 4;
  localparam int IRQ_FALL_CLR = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BLANK1 = 2'd1,
    ST_BLANK2 = 2'd2
  } blank_state_e;

endpackage

// File: rtl/pad_io_ctrl_debounce.sv
// Two-flop synchronizer followed by a run-length debounce filter; q_nxt_o is
// the level that q_o will take at the coming edge, used for same-edge edge detect.
module pad_debounce #(
  parameter int DbW     = 8,
  parameter int DbReset = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [DbW-1:0] thr_i,
  input  logic           clr_i,
  input  logic           d_i,
  output logic           q_o,
  output logic           q_nxt_o
);

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           lvl_q, lvl_d;
  logic [DbW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = d_i;
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (s2_q == lvl_q) begin
      cnt_d = '0;
    end else if ((thr_i <= DbW'(1)) || (cnt_q == thr_i - DbW'(1))) begin
      // Input has disagreed with the level for thr_i consecutive samples.
      lvl_d = s2_q;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DbW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o     = lvl_q;
  assign q_nxt_o = lvl_d;

endmodule

// File: rtl/pad_io_ctrl.sv
// Core-side controller for one bidirectional pad: output/OE/attribute drive with
// break-before-make on attribute changes, debounced input and sticky edge interrupts.
module pad_io_ctrl
  import pad_io_ctrl_pkg::*;
#(
  parameter int AttrDw  = 6,
  parameter int DbW     = 8,
  parameter int DbReset = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_addr_i,
  input  logic [7:0]        cfg_wdata_i,
  output logic              pad_out_o,
  output logic              pad_oe_o,
  output logic [AttrDw-1:0] pad_attr_o,
  input  logic              pad_in_i,
  output logic              in_level_o,
  output logic              rise_o,
  output logic              fall_o,
  output logic              irq_o
);

  logic wr_out, wr_attr, wr_dbnc, wr_irq;

  assign wr_out  = cfg_we_i && (cfg_addr_i == ADDR_OUT);
  assign wr_attr = cfg_we_i && (cfg_addr_i == ADDR_ATTR);
  assign wr_dbnc = cfg_we_i && (cfg_addr_i == ADDR_DBNC);
  assign wr_irq  = cfg_we_i && (cfg_addr_i == ADDR_IRQ);

  logic              out_q, out_d;
  logic              oe_q, oe_d;
  logic [AttrDw-1:0] attr_q, attr_d;
  logic [AttrDw-1:0] attr_lat_q, attr_lat_d;
  blank_state_e      state_q, state_d;
  logic [DbW-1:0]    thr_q, thr_d;
  logic              rise_en_q, rise_en_d;
  logic              fall_en_q, fall_en_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              irq_q, irq_d;
  logic              lvl, lvl_nxt;

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (wr_out) begin
      out_d = cfg_wdata_i[0];
      oe_d  = cfg_wdata_i[1];
    end
  end

  // Break-before-make: OE is held off across the cycle the attributes change.
  always_comb begin
    state_d    = state_q;
    attr_d     = attr_q;
    attr_lat_d = attr_lat_q;
    case (state_q)
      ST_RUN: begin
        if (wr_attr) begin
          attr_lat_d = AttrDw'(cfg_wdata_i);
          state_d    = ST_BLANK1;
        end
      end
      ST_BLANK1: begin
        attr_d  = attr_lat_q;
        state_d = ST_BLANK2;
        if (wr_attr) begin
          attr_lat_d = AttrDw'(cfg_wdata_i);
          state_d    = ST_BLANK1;
        end
      end
      ST_BLANK2: begin
        state_d = ST_RUN;
        if (wr_attr) begin
          attr_lat_d = AttrDw'(cfg_wdata_i);
          state_d    = ST_BLANK1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    thr_d     = thr_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_dbnc) begin
      thr_d = DbW'(cfg_wdata_i);
    end
    if (wr_irq) begin
      rise_en_d = cfg_wdata_i[IRQ_RISE_EN];
      fall_en_d = cfg_wdata_i[IRQ_FALL_EN];
    end
  end

  // Clears are applied first so a simultaneous set wins.
  always_comb begin
    rise_d = rise_q;
    fall_d = fall_q;
    if (wr_irq && cfg_wdata_i[IRQ_RISE_CLR]) rise_d = 1'b0;
    if (wr_irq && cfg_wdata_i[IRQ_FALL_CLR]) fall_d = 1'b0;
    if (rise_en_q && !lvl && lvl_nxt) rise_d = 1'b1;
    if (fall_en_q && lvl && !lvl_nxt) fall_d = 1'b1;
    irq_d = rise_d | fall_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= 1'b0;
      oe_q       <= 1'b0;
      attr_q     <= '0;
      attr_lat_q <= '0;
      state_q    <= ST_RUN;
      thr_q      <= DbW'(DbReset);
      rise_en_q  <= 1'b0;
      fall_en_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      attr_q     <= attr_d;
      attr_lat_q <= attr_lat_d;
      state_q    <= state_d;
      thr_q      <= thr_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      irq_q      <= irq_d;
    end
  end

  pad_debounce #(
    .DbW     (DbW),
    .DbReset (DbReset)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .thr_i   (thr_q),
    .clr_i   (wr_dbnc),
    .d_i     (pad_in_i),
    .q_o     (lvl),
    .q_nxt_o (lvl_nxt)
  );

  assign pad_out_o  = out_q;
  assign pad_oe_o   = oe_q && (state_q == ST_RUN);
  assign pad_attr_o = attr_q;
  assign in_level_o = lvl;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Directed checks of register writes, blanking, debounce latency and sticky
// status, followed by a randomized input phase against a windowed reference model.
module tb_pad_io_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       pad_out_o;
  logic       pad_oe_o;
  logic [5:0] pad_attr_o;
  logic       pad_in;
  logic       in_level_o;
  logic       rise_o;
  logic       fall_o;
  logic       irq_o;

  int checks = 0;
  int failures = 0;

  pad_io_ctrl #(
    .AttrDw  (6),
    .DbW     (8),
    .DbReset (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .pad_out_o   (pad_out_o),
    .pad_oe_o    (pad_oe_o),
    .pad_attr_o  (pad_attr_o),
    .pad_in_i    (pad_in),
    .in_level_o  (in_level_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until in_level_o reaches target, bounded at 20.
  task automatic wait_level(input logic target, output int n);
    n = 0;
    while (in_level_o !== target && n < 20) begin
      tick();
      n++;
    end
  endtask

  logic   pad_q[$];
  logic   s2_q[$];
  logic   m_level, m_rise, m_fall, s2v, flip;
  logic   pad_v, wr_en;
  logic [7:0] wd;
  int     need, run, n, lows, thr;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0; pad_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {pad_out_o, pad_oe_o, pad_attr_o, in_level_o, rise_o, fall_o, irq_o}, 32'd0);

    wr(2'd0, 8'h03);
    chk("out_write_out", pad_out_o, 1'b1);
    chk("out_write_oe", pad_oe_o, 1'b1);

    wr(2'd1, 8'h08);
    chk("attr_blank1_oe", pad_oe_o, 1'b0);
    tick();
    chk("attr_blank2_oe", pad_oe_o, 1'b0);
    chk("attr_new_after_2", pad_attr_o, 6'h08);
    tick();
    chk("attr_run_oe", pad_oe_o, 1'b1);

    lows = 0;
    wr(2'd1, 8'h01);
    if (!pad_oe_o) lows++;
    wr(2'd1, 8'h02);
    if (!pad_oe_o) lows++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!pad_oe_o) lows++;
    end
    chk("restart_oe_low_cycles", lows, 3);
    chk("restart_final_attr", pad_attr_o, 6'h02);

    wr(2'd1, 8'h04);
    wr(2'd0, 8'h02);
    chk("blank_out_update", pad_out_o, 1'b0);
    chk("blank_oe_forced", pad_oe_o, 1'b0);
    tick();
    chk("blank_oe_release", pad_oe_o, 1'b1);

    wr(2'd1, 8'h3f);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_blank", {pad_out_o, pad_oe_o, pad_attr_o}, 32'd0);
    tick();
    chk("reset_mid_blank_attr", pad_attr_o, 6'h00);

    // Default threshold 4: a 3-cycle pulse must be filtered out.
    pad_in = 1'b1;
    tick(); tick(); tick();
    pad_in = 1'b0;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (in_level_o) lows++;
    end
    chk("pulse_rejected", lows, 0);
    pad_in = 1'b1;
    wait_level(1'b1, n);
    chk("thr4_latency", n, 6);

    wr(2'd2, 8'h00);
    pad_in = 1'b0;
    wait_level(1'b0, n);
    chk("thr0_fall_latency", n, 3);
    pad_in = 1'b1;
    wait_level(1'b1, n);
    chk("thr0_rise_latency", n, 3);

    wr(2'd3, 8'h01);
    pad_in = 1'b0;
    wait_level(1'b0, n);
    chk("fall_disabled", {rise_o, fall_o, irq_o}, 3'b000);
    pad_in = 1'b1;
    wait_level(1'b1, n);
    chk("rise_set", {rise_o, irq_o}, 2'b11);
    wr(2'd3, 8'h11);
    chk("rise_clear", {rise_o, irq_o}, 2'b00);
    pad_in = 1'b0;
    wait_level(1'b0, n);
    pad_in = 1'b1;
    tick(); tick();
    wr(2'd3, 8'h11);
    chk("set_wins_level", in_level_o, 1'b1);
    chk("set_wins_status", {rise_o, irq_o}, 2'b11);
    wr(2'd3, 8'h11);
    chk("rise_clear2", {rise_o, irq_o}, 2'b00);
    wr(2'd3, 8'h02);
    pad_in = 1'b0;
    wait_level(1'b0, n);
    chk("fall_set", {rise_o, fall_o, irq_o}, 3'b011);
    wr(2'd3, 8'h22);
    chk("fall_clear", {fall_o, irq_o}, 2'b00);

    // Randomized phase: level flips once the synchronized input has
    // disagreed with it for max(thr,1) consecutive samples.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    thr = $urandom_range(0, 5);
    wr(2'd2, 8'(thr));
    wr(2'd3, 8'h03);
    for (int i = 0; i < 4; i++) tick();
    need = (thr == 0) ? 1 : thr;
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    pad_q.delete(); s2_q.delete();
    repeat (2) pad_q.push_back(1'b0);
    repeat (8) s2_q.push_back(1'b0);
    run = 0;
    pad_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (run == 0) begin
        pad_v = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 8);
      end
      run--;
      pad_in = pad_v;
      wr_en = ($urandom_range(0, 15) == 0);
      wd = {2'b00, 2'($urandom_range(0, 3)), 4'b0011};
      cfg_we = wr_en; cfg_addr = 2'd3; cfg_wdata = wd;
      @(posedge clk);
      s2v = pad_q[pad_q.size() - 2];
      pad_q.push_back(pad_v);
      s2_q.push_back(s2v);
      flip = 1'b1;
      for (int k = 0; k < need; k++)
        if (s2_q[s2_q.size() - 1 - k] == m_level) flip = 1'b0;
      if (wr_en && wd[4]) m_rise = 1'b0;
      if (wr_en && wd[5]) m_fall = 1'b0;
      if (flip) begin
        if (!m_level) m_rise = 1'b1;
        else m_fall = 1'b1;
        m_level = ~m_level;
      end
      #1;
      cfg_we = 1'b0;
      chk("rand_level", in_level_o, m_level);
      chk("rand_status", {rise_o, fall_o, irq_o}, {m_rise, m_fall, m_rise | m_fall});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
